// File: rtl/pcie_txpll_lock_sequencer.sv
// TX PLL lock sequencer: synchronises the PLL lock indications, holds the PCIe
// lane in reset until lock is stable, and re-sequences after a filtered loss.
module pcie_txpll_lock_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int UNLOCK_FILTER      = 8,
    parameter int TIMEOUT_CYCLES     = 65536,
    parameter int HOLDOFF_CYCLES     = 256,
    parameter int CNT_W              = 8
) (
    input  logic             CLK,
    input  logic             ARST_N,
    input  logic             PLL_LOCK,
    input  logic             LOCK,
    input  logic             RESTART,
    input  logic             CLR_STATS,
    output logic             LANE_RST_N,
    output logic             READY,
    output logic             FAULT,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] LOSS_CNT
);

    localparam int MAX_A   = (LOCK_STABLE_CYCLES > UNLOCK_FILTER) ? LOCK_STABLE_CYCLES : UNLOCK_FILTER;
    localparam int MAX_B   = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LAST  = TMR_W'(UNLOCK_FILTER - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLDOFF_LAST = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [CNT_W-1:0] LOSS_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_READY     = 3'd3,
        S_HOLDOFF   = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             state, state_nx;
    logic [TMR_W-1:0]   tmr, tmr_nx;
    logic [CNT_W-1:0]   loss_nx;
    logic               pll_lock_p0, pll_lock_p1;
    logic               lock_p0, lock_p1;
    logic               lock_ok;

    // Two-flop synchronisers for the asynchronous PLL lock indications
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            pll_lock_p0 <= 1'b0;
            pll_lock_p1 <= 1'b0;
            lock_p0     <= 1'b0;
            lock_p1     <= 1'b0;
        end else begin
            pll_lock_p0 <= PLL_LOCK;
            pll_lock_p1 <= pll_lock_p0;
            lock_p0     <= LOCK;
            lock_p1     <= lock_p0;
        end
    end

    assign lock_ok = pll_lock_p1 & lock_p1;

    // One shared counter serves as timeout timer, stable count, unlock filter
    // and holdoff timer, since only one of them is live in any state.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr + TMR_ONE;
        loss_nx  = LOSS_CNT;
        case (state)
            S_IDLE: begin
                state_nx = S_WAIT_LOCK;
                tmr_nx   = '0;
            end
            S_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_nx = S_STABLE;
                    tmr_nx   = '0;
                end else if (tmr == TIMEOUT_LAST) begin
                    state_nx = S_FAULT;
                    tmr_nx   = '0;
                end
            end
            S_STABLE: begin
                if (!lock_ok) begin
                    state_nx = S_WAIT_LOCK;
                    tmr_nx   = '0;
                end else if (tmr == STABLE_LAST) begin
                    state_nx = S_READY;
                    tmr_nx   = '0;
                end
            end
            S_READY: begin
                if (lock_ok) begin
                    tmr_nx = '0;
                end else if (tmr == UNLOCK_LAST) begin
                    state_nx = S_HOLDOFF;
                    tmr_nx   = '0;
                    if (LOSS_CNT != '1) begin
                        loss_nx = LOSS_CNT + LOSS_ONE;
                    end
                end
            end
            S_HOLDOFF: begin
                if (tmr == HOLDOFF_LAST) begin
                    state_nx = S_WAIT_LOCK;
                    tmr_nx   = '0;
                end
            end
            S_FAULT: begin
                tmr_nx = '0;
            end
            default: begin
                state_nx = S_IDLE;
                tmr_nx   = '0;
            end
        endcase

        if (RESTART && (state != S_IDLE)) begin
            state_nx = S_IDLE;
            tmr_nx   = '0;
        end
        if (CLR_STATS) begin
            loss_nx = '0;
        end
    end

    // Outputs decode the next state so they move on the same edge as STATE
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state      <= S_IDLE;
            tmr        <= '0;
            LOSS_CNT   <= '0;
            LANE_RST_N <= 1'b0;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            state      <= state_nx;
            tmr        <= tmr_nx;
            LOSS_CNT   <= loss_nx;
            LANE_RST_N <= (state_nx == S_READY);
            READY      <= (state_nx == S_READY);
            FAULT      <= (state_nx == S_FAULT);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_pcie_txpll_lock_sequencer.sv
// Bench for pcie_txpll_lock_sequencer: directed scenarios plus randomized lock
// activity, all compared against a behavioural model of the sequencing rules.
`timescale 1ns/1ps
module tb_pcie_txpll_lock_sequencer;

    localparam int LSC      = 16;
    localparam int UF       = 4;
    localparam int TO       = 64;
    localparam int HO       = 8;
    localparam int CW       = 8;
    localparam int LOSS_MAX = (1 << CW) - 1;

    logic          CLK       = 1'b0;
    logic          ARST_N    = 1'b1;
    logic          PLL_LOCK  = 1'b0;
    logic          LOCK      = 1'b0;
    logic          RESTART   = 1'b0;
    logic          CLR_STATS = 1'b0;
    logic          LANE_RST_N;
    logic          READY;
    logic          FAULT;
    logic [2:0]    STATE;
    logic [CW-1:0] LOSS_CNT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pcie_txpll_lock_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .UNLOCK_FILTER      (UF),
        .TIMEOUT_CYCLES     (TO),
        .HOLDOFF_CYCLES     (HO),
        .CNT_W              (CW)
    ) dut (
        .CLK        (CLK),
        .ARST_N     (ARST_N),
        .PLL_LOCK   (PLL_LOCK),
        .LOCK       (LOCK),
        .RESTART    (RESTART),
        .CLR_STATS  (CLR_STATS),
        .LANE_RST_N (LANE_RST_N),
        .READY      (READY),
        .FAULT      (FAULT),
        .STATE      (STATE),
        .LOSS_CNT   (LOSS_CNT)
    );

    // Reference model: mode numbers are the published STATE codes
    int m_mode, m_timer, m_stable, m_unlock, m_hold, m_loss;
    bit m_pipe[$];

    task automatic model_reset();
        m_mode = 0; m_timer = 0; m_stable = 0; m_unlock = 0; m_hold = 0; m_loss = 0;
        m_pipe.delete();
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
    endtask

    task automatic model_edge(input bit pl, input bit lk, input bit rs, input bit cs);
        bit ok;
        ok = m_pipe.pop_front();
        m_pipe.push_back(pl & lk);
        if (rs && m_mode != 0) begin
            m_mode = 0; m_timer = 0; m_stable = 0; m_unlock = 0; m_hold = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_timer = 0; end
                1: begin
                    if (ok) begin m_mode = 2; m_stable = 0; end
                    else if (m_timer == TO - 1) m_mode = 5;
                    else m_timer++;
                end
                2: begin
                    if (!ok) begin m_mode = 1; m_timer = 0; end
                    else if (m_stable == LSC - 1) begin m_mode = 3; m_unlock = 0; end
                    else m_stable++;
                end
                3: begin
                    if (ok) m_unlock = 0;
                    else if (m_unlock == UF - 1) begin
                        m_mode = 4; m_hold = 0;
                        m_loss = (m_loss < LOSS_MAX) ? m_loss + 1 : LOSS_MAX;
                    end else m_unlock++;
                end
                4: begin
                    if (m_hold == HO - 1) begin m_mode = 1; m_timer = 0; end
                    else m_hold++;
                end
                default: ;
            endcase
        end
        if (cs) m_loss = 0;
    endtask

    function automatic logic [13:0] exp_vec();
        return {m_mode[2:0], (m_mode == 3), (m_mode == 3), (m_mode == 5), m_loss[7:0]};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {STATE, READY, LANE_RST_N, FAULT, LOSS_CNT};
    endfunction

    task automatic edge_step(input bit pl, input bit lk, input bit rs, input bit cs);
        PLL_LOCK = pl; LOCK = lk; RESTART = rs; CLR_STATS = cs;
        @(posedge CLK);
        model_edge(pl, lk, rs, cs);
        #1;
        RESTART = 1'b0; CLR_STATS = 1'b0;
    endtask

    task automatic goto_mode(input int mode, input bit pl, input bit lk, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            edge_step(pl, lk, 1'b0, 1'b0);
            hit = (m_mode == mode);
        end
    endtask

    task automatic test_reset();
        #2 ARST_N = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (dut_vec() !== 14'd0) begin
            errors++; $display("FAIL reset_values: got %h expected %h", dut_vec(), 14'd0);
        end
        ARST_N = 1'b1;
    endtask

    task automatic test_lock_up();
        int ready_edge = -1;
        bit fault_seen = 1'b0;
        logic [2:0] seen[$];
        seen.push_back(STATE);
        for (int e = 1; e <= 40; e++) begin
            edge_step(e >= 11, e >= 11, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL lockup_edge%0d: got %h expected %h", e, dut_vec(), exp_vec());
            end
            if (READY === 1'b1 && ready_edge < 0) ready_edge = e;
            if (seen[$] !== STATE) seen.push_back(STATE);
            if (FAULT !== 1'b0) fault_seen = 1'b1;
        end
        checks++;
        if (ready_edge != 29) begin
            errors++; $display("FAIL lockup_ready_edge: got %0d expected 29", ready_edge);
        end
        checks++;
        if (seen.size() != 4 || seen[0] !== 3'd0 || seen[1] !== 3'd1 || seen[2] !== 3'd2 || seen[3] !== 3'd3) begin
            errors++; $display("FAIL lockup_state_seq: got %0d states, last %0d, expected 0,1,2,3", seen.size(), seen[$]);
        end
        checks++;
        if (fault_seen) begin
            errors++; $display("FAIL lockup_fault: got 1 expected 0");
        end
    endtask

    task automatic test_unlock_filter();
        int hold_cycles = 0;
        for (int e = 0; e < 8; e++) begin
            edge_step(1'b1, !(e < 3), 1'b0, 1'b0);
            checks++;
            if ({STATE, READY, LANE_RST_N, LOSS_CNT} !== {3'd3, 1'b1, 1'b1, 8'd0}) begin
                errors++; $display("FAIL glitch3_no_change: got st=%0d rdy=%b lrn=%b loss=%0d expected st=3 rdy=1 lrn=1 loss=0",
                                   STATE, READY, LANE_RST_N, LOSS_CNT);
            end
        end
        for (int e = 0; e < 40; e++) begin
            edge_step(1'b1, !(e < 4), 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL unlock4_cycle%0d: got %h expected %h", e, dut_vec(), exp_vec());
            end
            if (STATE === 3'd4) hold_cycles++;
        end
        checks++;
        if (hold_cycles != HO) begin
            errors++; $display("FAIL holdoff_length: got %0d expected %0d", hold_cycles, HO);
        end
        checks++;
        if (LOSS_CNT !== 8'd1 || READY !== 1'b1) begin
            errors++; $display("FAIL relock_after_loss: got loss=%0d rdy=%b expected loss=1 rdy=1", LOSS_CNT, READY);
        end
    endtask

    task automatic test_timeout();
        int fault_edge = -1;
        logic [CW-1:0] loss_keep;
        bit hit;
        loss_keep = LOSS_CNT;
        edge_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (STATE !== 3'd0 || LANE_RST_N !== 1'b0) begin
            errors++; $display("FAIL restart_to_idle: got st=%0d lrn=%b expected st=0 lrn=0", STATE, LANE_RST_N);
        end
        for (int e = 1; e <= 70; e++) begin
            edge_step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL timeout_edge%0d: got %h expected %h", e, dut_vec(), exp_vec());
            end
            if (FAULT === 1'b1 && fault_edge < 0) fault_edge = e;
        end
        checks++;
        if (fault_edge != TO + 1) begin
            errors++; $display("FAIL timeout_edge: got %0d expected %0d", fault_edge, TO + 1);
        end
        for (int e = 0; e < 20; e++) begin
            edge_step(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (STATE !== 3'd5 || FAULT !== 1'b1 || LANE_RST_N !== 1'b0) begin
                errors++; $display("FAIL fault_sticky: got st=%0d flt=%b lrn=%b expected st=5 flt=1 lrn=0", STATE, FAULT, LANE_RST_N);
            end
        end
        edge_step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (STATE !== 3'd0 || FAULT !== 1'b0) begin
            errors++; $display("FAIL fault_restart: got st=%0d flt=%b expected st=0 flt=0", STATE, FAULT);
        end
        goto_mode(3, 1'b1, 1'b1, 40, hit);
        checks++;
        if (!hit || READY !== 1'b1 || LOSS_CNT !== loss_keep) begin
            errors++; $display("FAIL fault_recover: got rdy=%b loss=%0d expected rdy=1 loss=%0d", READY, LOSS_CNT, loss_keep);
        end
    endtask

    task automatic test_stable_glitch();
        int back_edge = -1;
        int ready_edge = -1;
        bit hit = 1'b0;
        edge_step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12 && !hit; i++) begin
            edge_step(1'b1, 1'b1, 1'b0, 1'b0);
            hit = (m_mode == 2 && m_stable == 8);
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL stable_reach: got mode=%0d expected STABLE count 8", m_mode);
        end
        for (int i = 0; i <= 30; i++) begin
            edge_step(i != 0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL stable_glitch_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (STATE === 3'd1 && back_edge < 0) back_edge = i;
            if (READY === 1'b1 && ready_edge < 0) ready_edge = i;
        end
        checks++;
        if (back_edge != 2 || ready_edge - back_edge != LSC + 1) begin
            errors++; $display("FAIL stable_restart_count: got back=%0d ready=%0d expected back=2 ready=%0d", back_edge, ready_edge, 3 + LSC);
        end
    endtask

    task automatic test_loss_saturation();
        bit hit, hit2;
        bit cs;
        edge_step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (LOSS_CNT !== 8'd0) begin
            errors++; $display("FAIL clr_stats: got %0d expected 0", LOSS_CNT);
        end
        for (int n = 1; n <= 256; n++) begin
            goto_mode(4, 1'b0, 1'b0, 10, hit);
            goto_mode(3, 1'b1, 1'b1, 40, hit2);
            checks++;
            if (!hit || !hit2 || dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL loss_event%0d: got %h expected %h", n, dut_vec(), exp_vec());
            end
            if (n == 255) begin
                checks++;
                if (LOSS_CNT !== 8'd255) begin
                    errors++; $display("FAIL loss_255: got %0d expected 255", LOSS_CNT);
                end
            end
        end
        checks++;
        if (LOSS_CNT !== 8'd255) begin
            errors++; $display("FAIL loss_saturate: got %0d expected 255", LOSS_CNT);
        end
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cs = (m_mode == 3 && m_unlock == UF - 1 && !m_pipe[0]);
            edge_step(1'b0, 1'b0, 1'b0, cs);
            hit = cs;
        end
        checks++;
        if (!hit || LOSS_CNT !== 8'd0 || STATE !== 3'd4) begin
            errors++; $display("FAIL clr_wins: got loss=%0d st=%0d expected loss=0 st=4", LOSS_CNT, STATE);
        end
    endtask

    task automatic test_async_reset();
        bit hit;
        edge_step(1'b1, 1'b1, 1'b0, 1'b0);
        #3 ARST_N = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 14'd0) begin
            errors++; $display("FAIL areset_holdoff: got %h expected %h", dut_vec(), 14'd0);
        end
        @(posedge CLK); #1;
        ARST_N = 1'b1;
        model_reset();
        goto_mode(2, 1'b1, 1'b1, 20, hit);
        edge_step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!hit || STATE !== 3'd2) begin
            errors++; $display("FAIL reach_stable: got st=%0d expected 2", STATE);
        end
        #3 ARST_N = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 14'd0) begin
            errors++; $display("FAIL areset_stable: got %h expected %h", dut_vec(), 14'd0);
        end
        @(posedge CLK); #1;
        ARST_N = 1'b1;
        model_reset();
        goto_mode(3, 1'b1, 1'b1, 40, hit);
        edge_step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (!hit || LANE_RST_N !== 1'b0 || STATE !== 3'd0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL restart_in_ready: got st=%0d lrn=%b expected st=0 lrn=0", STATE, LANE_RST_N);
        end
    endtask

    task automatic test_random();
        bit pl = 1'b1;
        bit lk = 1'b1;
        bit rs, cs;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                pl = ($urandom_range(0, 3) != 0);
                lk = ($urandom_range(0, 3) != 0);
            end
            rs = ($urandom_range(0, 149) == 0);
            cs = ($urandom_range(0, 99) == 0);
            edge_step(pl, lk, rs, cs);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_unlock_filter();
        test_timeout();
        test_stable_glitch();
        test_loss_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pcie_txpll_lock_sequencer.md
Name: pcie_txpll_lock_sequencer

Overview:
Sequences bring-up and lock supervision of the PCIe transmit PLL. It synchronises the PLL's PLL_LOCK and LOCK outputs into the fabric clock domain and debounces them. It holds the PCIe lane in reset until lock has been stable for a programmed time, and re-sequences the lane after a filtered loss of lock. It sits between the TX PLL component and the PCIe lane/controller reset inputs, and exposes status to the fabric.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before the lane is released (min 2)
UNLOCK_FILTER, 8, consecutive unlocked cycles in READY that count as a real loss of lock (min 1)
TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before FAULT (min 2)
HOLDOFF_CYCLES, 256, cycles the lane is held in reset after a loss of lock (min 1)
CNT_W, 8, width of the saturating loss-of-lock counter

Ports:
CLK  in  1  fabric clock; the only clock
ARST_N  in  1  asynchronous active-low reset
PLL_LOCK  in  1  TX PLL fabric lock; asynchronous to CLK
LOCK  in  1  TX PLL lock; asynchronous to CLK
RESTART  in  1  single-cycle pulse; restarts the sequence from IDLE
CLR_STATS  in  1  single-cycle pulse; clears LOSS_CNT
LANE_RST_N  out  1  active-low lane/controller reset; high only in READY
READY  out  1  PLL locked and stable; lane released
FAULT  out  1  lock timeout occurred
STATE  out  3  current state encoding
LOSS_CNT  out  CNT_W  saturating count of filtered loss-of-lock events

Behaviour:
- Clocking and reset: single clock CLK. Reset ARST_N is asynchronous assert, active-low; deassertion is taken as already synchronised to CLK.
- Reset values: state IDLE; LANE_RST_N=0; READY=0; FAULT=0; LOSS_CNT=0; STATE=0; all counters and synchronisers 0.
- Input synchronisation: PLL_LOCK and LOCK each pass through a 2-flop synchroniser. lock_ok = sync(PLL_LOCK) AND sync(LOCK). All decisions use lock_ok only.
- Outputs: all registered, decoded from the next state, so they change on the same edge as STATE.
- State encodings: IDLE=0, WAIT_LOCK=1, STABLE=2, READY=3, HOLDOFF=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE: goes unconditionally to WAIT_LOCK on the next edge; clears the timer.
- WAIT_LOCK:
  - Timer increments each cycle.
  - If lock_ok is high, go to STABLE and clear the stable counter.
  - Otherwise, if timer = TIMEOUT_CYCLES-1, go to FAULT.
  - If lock_ok is high on the timeout cycle, lock wins.
- STABLE:
  - Counter increments while lock_ok is high.
  - If lock_ok is low, return to WAIT_LOCK with the timer cleared. LOSS_CNT is unchanged.
  - If counter = LOCK_STABLE_CYCLES-1 and lock_ok is high, go to READY.
- READY:
  - LANE_RST_N=1 and READY=1.
  - The unlock counter increments while lock_ok is low and clears when lock_ok is high.
  - When the unlock counter reaches UNLOCK_FILTER-1 with lock_ok low, go to HOLDOFF and increment LOSS_CNT, saturating at all-ones.
  - Unlock glitches shorter than UNLOCK_FILTER cycles produce no output change.
- HOLDOFF: LANE_RST_N=0 for exactly HOLDOFF_CYCLES cycles, regardless of lock_ok. Then go to WAIT_LOCK with the timer cleared.
- FAULT:
  - FAULT=1 and LANE_RST_N=0.
  - Sticky; leaves only on RESTART or reset.
  - A lock appearing while in FAULT is ignored.
- RESTART:
  - In any state other than IDLE, go to IDLE on the next edge and clear all timers.
  - FAULT is cleared; LOSS_CNT is kept.
  - RESTART has priority over every other transition.
- CLR_STATS: LOSS_CNT=0 on the next edge. If it coincides with an increment, the clear wins and the result is 0.
- Latency: READY rises LOCK_STABLE_CYCLES+3 CLK edges after the first edge that samples both PLL_LOCK and LOCK high from WAIT_LOCK (2 sync + 1 transition + stable count).
- Reset mid-operation: outputs return to reset values immediately and asynchronously.

Test Plan:
Bench parameters: LOCK_STABLE_CYCLES=16, UNLOCK_FILTER=4, TIMEOUT_CYCLES=64, HOLDOFF_CYCLES=8, CNT_W=8.
1. Release reset, raise PLL_LOCK and LOCK at edge 10 -> STATE passes 0,1,2,3; READY and LANE_RST_N rise at edge 29; FAULT stays 0.
2. In READY, drop LOCK for 3 cycles -> no output change, LOSS_CNT=0. Then drop it for 4 cycles -> HOLDOFF with LANE_RST_N=0 for exactly 8 cycles, LOSS_CNT=1, then WAIT_LOCK, then READY again after 19 edges of stable lock.
3. Keep locks low for 64 cycles after IDLE -> FAULT=1 and STATE=5. Raise locks -> stays in FAULT. Pulse RESTART -> IDLE, then normal lock to READY; LOSS_CNT unchanged.
4. In STABLE at count 10, drop PLL_LOCK for 1 cycle -> STATE returns to 1, READY stays 0, LOSS_CNT=0; the full 16-cycle count restarts.
5. Force 255 loss events -> LOSS_CNT=255. Force one more -> stays 255. Pulse CLR_STATS on the same edge as a loss increment -> LOSS_CNT=0.
6. Assert ARST_N low mid-STABLE and mid-HOLDOFF -> all outputs at reset values within the reset assertion, without a CLK edge. Pulse RESTART in READY -> LANE_RST_N=0 and STATE=0 on the next edge.
